// File: rtl/chan_fifo_buffer.sv
// Multi-channel FIFO buffer: NUM_CH independent queues that share one write port, one read port
// and one flush port. Read data is registered with one cycle of latency, and error pulses are registered.
module chan_fifo_buffer #(
  parameter int NUM_CH  = 4,
  parameter int CH_BW   = 2,
  parameter int ADDR_BW = 2,
  parameter int DATA_BW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [CH_BW-1:0]   wr_ch,
  input  logic [DATA_BW-1:0] din,
  input  logic               rd_en,
  input  logic [CH_BW-1:0]   rd_ch,
  input  logic               flush,
  input  logic [CH_BW-1:0]   flush_ch,
  output logic [DATA_BW-1:0] dout,
  output logic               dout_valid,
  output logic [NUM_CH-1:0]  full,
  output logic [NUM_CH-1:0]  empty,
  output logic               wr_err,
  output logic               rd_err
);

  localparam int                 DEPTH    = 2 ** ADDR_BW;
  localparam logic [ADDR_BW:0]   CNT_FULL = {1'b1, {ADDR_BW{1'b0}}};
  localparam logic [ADDR_BW:0]   CNT_ONE  = (ADDR_BW + 1)'(1'b1);
  localparam logic [ADDR_BW-1:0] PTR_ONE  = ADDR_BW'(1'b1);

  logic [DATA_BW-1:0] mem_q [NUM_CH][DEPTH];

  logic [ADDR_BW-1:0] wr_ptr_q [NUM_CH];
  logic [ADDR_BW-1:0] wr_ptr_d [NUM_CH];
  logic [ADDR_BW-1:0] rd_ptr_q [NUM_CH];
  logic [ADDR_BW-1:0] rd_ptr_d [NUM_CH];
  logic [ADDR_BW:0]   cnt_q    [NUM_CH];
  logic [ADDR_BW:0]   cnt_d    [NUM_CH];

  logic [DATA_BW-1:0] dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               wr_err_q, wr_err_d;
  logic               rd_err_q, rd_err_d;

  logic [NUM_CH-1:0]  wr_hit, rd_hit, fl_hit;
  logic [NUM_CH-1:0]  wr_acc, rd_acc;

  // Status flags come straight from the registered counts.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]  = (cnt_q[c] == CNT_FULL);
      empty[c] = (cnt_q[c] == '0);
    end
  end

  // Request decode per channel. An out-of-range select matches no channel, so it is rejected.
  // A read's acceptance never depends on a write, so a pop can free room for a write to a full channel.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    fl_hit = '0;
    rd_acc = '0;
    wr_acc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = wr_en && (wr_ch == CH_BW'(c));
      rd_hit[c] = rd_en && (rd_ch == CH_BW'(c));
      fl_hit[c] = flush && (flush_ch == CH_BW'(c));
      rd_acc[c] = rd_hit[c] && !fl_hit[c] && !empty[c];
      wr_acc[c] = wr_hit[c] && !fl_hit[c] && (!full[c] || rd_acc[c]);
    end
  end

  // Pointer and count next state; flush wins over traffic on its own channel.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
      if (fl_hit[c]) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end else begin
        if (wr_acc[c]) begin
          wr_ptr_d[c] = wr_ptr_q[c] + PTR_ONE;
        end else begin
          wr_ptr_d[c] = wr_ptr_q[c];
        end
        if (rd_acc[c]) begin
          rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
        end else begin
          rd_ptr_d[c] = rd_ptr_q[c];
        end
        case ({wr_acc[c], rd_acc[c]})
          2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
          2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
          default: cnt_d[c] = cnt_q[c];
        endcase
      end
    end
  end

  // Read data and error pulses. Dropping a request because of a flush is not an error.
  always_comb begin
    dout_d       = '0;
    dout_valid_d = |rd_acc;
    wr_err_d     = wr_en && !(|wr_acc) && !(|(wr_hit & fl_hit));
    rd_err_d     = rd_en && !(|rd_acc) && !(|(rd_hit & fl_hit));
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_acc[c]) begin
        dout_d = mem_q[c][rd_ptr_q[c]];
      end else begin
        dout_d = dout_d;
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      wr_err_q     <= wr_err_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Storage needs no reset: the counts keep stale entries from ever being read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_acc[c] && !rst) begin
        mem_q[c][wr_ptr_q[c]] <= din;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign wr_err     = wr_err_q;
  assign rd_err     = rd_err_q;

endmodule

// File: doc/chan_fifo_buffer.md
CHAN_FIFO_BUFFER -- requirements
Module: chan_fifo_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent FIFO channels.
REQ-002 SHALL have parameter CH_BW, default 2, channel-select width; NUM_CH <= 2**CH_BW.
REQ-003 SHALL have parameter ADDR_BW, default 2, per-channel depth 2**ADDR_BW entries.
REQ-004 SHALL have parameter DATA_BW, default 4, entry width.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_ch  input  CH_BW  write channel select.
REQ-009 SHALL have port din  input  DATA_BW  write data.
REQ-010 SHALL have port rd_en  input  1  read (pop) request.
REQ-011 SHALL have port rd_ch  input  CH_BW  read channel select.
REQ-012 SHALL have port flush  input  1  channel clear request.
REQ-013 SHALL have port flush_ch  input  CH_BW  channel to clear.
REQ-014 SHALL have port dout  output  DATA_BW  registered read data.
REQ-015 SHALL have port dout_valid  output  1  dout holds popped data this cycle.
REQ-016 SHALL have port full  output  NUM_CH  per-channel full flags.
REQ-017 SHALL have port empty  output  NUM_CH  per-channel empty flags.
REQ-018 SHALL have port wr_err  output  1  registered pulse, write rejected.
REQ-019 SHALL have port rd_err  output  1  registered pulse, read rejected.

Function
REQ-020 SHALL keep per channel a write pointer and read pointer (ADDR_BW bits, wrap 2**ADDR_BW-1 -> 0) and a count (ADDR_BW+1 bits, range 0..2**ADDR_BW).
REQ-021 SHALL drive full[c] = (count[c] == 2**ADDR_BW) and empty[c] = (count[c] == 0) combinationally from registered counts.
REQ-022 SHALL accept a write when wr_en, wr_ch < NUM_CH, and channel not full: store din at wr pointer, increment wr pointer.
REQ-023 SHALL accept a read when rd_en, rd_ch < NUM_CH, and channel not empty: next cycle dout = entry at rd pointer and dout_valid = 1; increment rd pointer.
REQ-024 SHALL drive dout = 0 and dout_valid = 0 in any cycle following a non-accepted or absent read (1-cycle read latency, no hold).
REQ-025 SHALL, on simultaneous accepted read and write to the same channel, leave count unchanged and advance both pointers.
REQ-026 SHALL, for write to a full channel with same-cycle accepted read on that channel, accept the write (full-with-pop pass-through).
REQ-027 SHALL NOT bypass: read of an empty channel with same-cycle write to it is rejected; the write is accepted.
REQ-028 SHALL pulse wr_err = 1 for one cycle after a rejected write (full without same-cycle pop, or wr_ch >= NUM_CH); no state change.
REQ-029 SHALL pulse rd_err = 1 for one cycle after a rejected read (empty, or rd_ch >= NUM_CH); dout_valid = 0.
REQ-030 SHALL, on flush with flush_ch < NUM_CH, set that channel's pointers and count to 0 at the next edge; flush takes priority over same-cycle read/write to that channel, which are dropped without error pulses; reads/writes to other channels proceed normally.
REQ-031 SHALL operate channels independently; reads/writes to distinct channels in the same cycle both take effect.

Reset
REQ-032 SHALL, while rst = 1, clear all pointers and counts, dout = 0, dout_valid = 0, wr_err = 0, rd_err = 0; full = 0, empty = all ones next cycle.
REQ-033 SHALL give rst priority over all requests; in-flight read data is discarded (dout_valid = 0 the cycle after rst).
REQ-034 SHALL NOT require storage array reset; stale contents never appear on dout because count gates reads.

Verification
REQ-035 Fill/drain: write 0x1,0x2,0x3,0x4 to ch2, then 5 reads -> dout 0x1..0x4 each 1 cycle after its read, full[2]=1 after 4th write, 5th read -> rd_err=1, dout=0.
REQ-036 Overflow: ch0 full, wr_en din=0xF without pop -> wr_err=1, later drain returns original 4 entries only; repeat with same-cycle pop -> write accepted, full[0] stays 1.
REQ-037 Wrap-around: 10 alternating write/read pairs on ch1 with values 0..9 -> dout sequence 0..9, empty[1]=1 at end, no errors.
REQ-038 Empty same-cycle: ch3 empty, rd_en+wr_en ch3 din=0xA -> rd_err=1, next read returns 0xA.
REQ-039 Flush/reset mid-operation: ch0 holds 3 entries, flush ch0 with simultaneous write ch0 and read ch1 -> empty[0]=1, ch1 read valid, no errors; assert rst during a read -> dout_valid=0, all empty.
